// File: rtl/sdr_ref_seq.sv
// sdr_ref_seq: refresh command sequencer. Issues PRECHARGE-ALL followed by
// one or more AUTO-REFRESH commands, times tRP/tRC, reports refresh status
// back to the refresh-check stage and keeps rd/wr grants off the bus while
// a refresh sequence owns it. All outputs come straight from flops.
module sdr_ref_seq #(
    parameter int TRP_CYC = 3,
    parameter int TRC_CYC = 8,
    parameter int CNT_W   = 4
) (
    input  logic       mclk,
    input  logic       s_resetn,
    input  logic       init_done,
    input  logic       ref_set,
    input  logic       ref_end,
    input  logic       wen,
    input  logic       ren,
    input  logic       busy_rw,
    output logic       cs_n,
    output logic [2:0] cmd_n,
    output logic       a10,
    output logic       st_ref,
    output logic       trca_end,
    output logic       ref_active,
    output logic       rw_grant
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_RW = 3'd1,
        PRE     = 3'd2,
        TRP     = 3'd3,
        AREF    = 3'd4,
        TRC     = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [2:0]       CMD_NOP  = 3'b111;
    localparam logic [2:0]       CMD_PRE  = 3'b010;
    localparam logic [2:0]       CMD_REF  = 3'b001;
    localparam logic [CNT_W-1:0] TRP_LOAD = CNT_W'(TRP_CYC - 1);
    localparam logic [CNT_W-1:0] TRC_LOAD = CNT_W'(TRC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ref_flag_q, ref_flag_d;
    logic             cs_n_q, cs_n_d;
    logic [2:0]       cmd_n_q, cmd_n_d;
    logic             a10_q, a10_d;
    logic             st_ref_q, st_ref_d;
    logic             trca_end_q, trca_end_d;
    logic             ref_active_q, ref_active_d;
    logic             rw_grant_q, rw_grant_d;

    // Next-state, timer, ref_end flag and the output values for the next cycle.
    // The timer is loaded on the edge that enters PRE/AREF, so the value seen
    // during a state is the number of cycles still to wait after it.
    always_comb begin
        state_d      = state_q;
        timer_d      = (timer_q != '0) ? timer_q - CNT_ONE : timer_q;
        ref_flag_d   = ref_flag_q;
        rw_grant_d   = 1'b0;

        case (state_q)
            IDLE: begin
                ref_flag_d = 1'b0;
                if (init_done && ref_set) begin
                    state_d = busy_rw ? WAIT_RW : PRE;
                end else if (init_done && (wen || ren) && !rw_grant_q) begin
                    rw_grant_d = 1'b1;
                end
            end
            WAIT_RW: begin
                if (!busy_rw) state_d = PRE;
            end
            PRE: begin
                // With TRP_CYC=1 no wait state is needed before AUTO-REFRESH.
                state_d = (timer_q == '0) ? AREF : TRP;
            end
            TRP: begin
                if (timer_q == '0) state_d = AREF;
            end
            AREF: begin
                state_d = TRC;
            end
            TRC: begin
                if (ref_end && trca_end_q) ref_flag_d = 1'b1;
                if (timer_q == '0) begin
                    if (ref_flag_q || (ref_end && trca_end_q)) state_d = DONE;
                    else if (ref_set)                            state_d = AREF;
                    else                                         state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == PRE)  timer_d = TRP_LOAD;
        if (state_d == AREF) begin
            timer_d    = TRC_LOAD;
            ref_flag_d = 1'b0;
        end

        // Losing init_done abandons the sequence; commands already issued stand.
        if (!init_done) begin
            state_d    = IDLE;
            timer_d    = '0;
            ref_flag_d = 1'b0;
            rw_grant_d = 1'b0;
        end

        cs_n_d  = 1'b1;
        cmd_n_d = CMD_NOP;
        a10_d   = 1'b0;
        if (state_d == PRE) begin
            cs_n_d  = 1'b0;
            cmd_n_d = CMD_PRE;
            a10_d   = 1'b1;
        end else if (state_d == AREF) begin
            cs_n_d  = 1'b0;
            cmd_n_d = CMD_REF;
        end
        st_ref_d     = (state_d == AREF) || (state_d == TRC);
        trca_end_d   = (state_d == TRC) && (timer_d <= CNT_ONE);
        ref_active_d = (state_d != IDLE);
    end

    // State, timer, flag and registered outputs with synchronous active-low reset.
    always_ff @(posedge mclk) begin
        if (!s_resetn) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            ref_flag_q   <= 1'b0;
            cs_n_q       <= 1'b1;
            cmd_n_q      <= CMD_NOP;
            a10_q        <= 1'b0;
            st_ref_q     <= 1'b0;
            trca_end_q   <= 1'b0;
            ref_active_q <= 1'b0;
            rw_grant_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ref_flag_q   <= ref_flag_d;
            cs_n_q       <= cs_n_d;
            cmd_n_q      <= cmd_n_d;
            a10_q        <= a10_d;
            st_ref_q     <= st_ref_d;
            trca_end_q   <= trca_end_d;
            ref_active_q <= ref_active_d;
            rw_grant_q   <= rw_grant_d;
        end
    end

    assign cs_n       = cs_n_q;
    assign cmd_n      = cmd_n_q;
    assign a10        = a10_q;
    assign st_ref     = st_ref_q;
    assign trca_end   = trca_end_q;
    assign ref_active = ref_active_q;
    assign rw_grant   = rw_grant_q;

endmodule

// File: tb/tb_sdr_ref_seq.sv
// tb_sdr_ref_seq: directed bench for the refresh sequencer. Each step drives
// inputs, queues the output vector expected after the next mclk edge, then
// pops and compares it 1 ns after that edge.
module tb_sdr_ref_seq;

    logic       mclk = 1'b0;
    logic       s_resetn, init_done, ref_set, ref_end, wen, ren, busy_rw;
    logic       cs_n, a10, st_ref, trca_end, ref_active, rw_grant;
    logic [2:0] cmd_n;

    // {cs_n, cmd_n[2:0], a10, st_ref, trca_end, ref_active, rw_grant}
    localparam logic [8:0] NOP_I = 9'b1_111_0_0_0_0_0;
    localparam logic [8:0] NOP_A = 9'b1_111_0_0_0_1_0;
    localparam logic [8:0] PREC  = 9'b0_010_1_0_0_1_0;
    localparam logic [8:0] AREFC = 9'b0_001_0_1_0_1_0;
    localparam logic [8:0] TRC_S = 9'b1_111_0_1_0_1_0;
    localparam logic [8:0] TRC_E = 9'b1_111_0_1_1_1_0;
    localparam logic [8:0] GRANT = 9'b1_111_0_0_0_0_1;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    sdr_ref_seq #(.TRP_CYC(3), .TRC_CYC(8), .CNT_W(4)) dut (
        .mclk(mclk), .s_resetn(s_resetn), .init_done(init_done),
        .ref_set(ref_set), .ref_end(ref_end), .wen(wen), .ren(ren),
        .busy_rw(busy_rw), .cs_n(cs_n), .cmd_n(cmd_n), .a10(a10),
        .st_ref(st_ref), .trca_end(trca_end), .ref_active(ref_active),
        .rw_grant(rw_grant)
    );

    always #5 mclk = ~mclk;

    task automatic step(input logic [8:0] exp, input string tag);
        logic [8:0] got;
        logic [8:0] want;
        exp_q.push_back(exp);
        @(posedge mclk);
        #1;
        want = exp_q.pop_front();
        got  = {cs_n, cmd_n, a10, st_ref, trca_end, ref_active, rw_grant};
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic trc_body(input string tag);
        for (int i = 0; i < 5; i++) step(TRC_S, tag);
        step(TRC_E, tag);
        step(TRC_E, tag);
    endtask

    initial begin
        s_resetn = 1'b0; init_done = 1'b0; ref_set = 1'b1; ref_end = 1'b0;
        wen = 1'b0; ren = 1'b0; busy_rw = 1'b0;

        // Reset with refresh requested
        init_done = 1'b1;
        for (int i = 0; i < 4; i++) step(NOP_I, "reset");
        s_resetn = 1'b1; ref_set = 1'b0;
        step(NOP_I, "idle_after_reset");

        // Plain grant in IDLE
        ren = 1'b1; step(GRANT, "grant_ren");
        ren = 1'b0; step(NOP_I, "grant_one_cycle");

        // Single refresh: PRE at 1, AREF at 4, trca_end 10-11, ref_end at 11
        ref_set = 1'b1; step(PREC, "single_pre");
        ref_set = 1'b0; step(NOP_A, "single_trp"); step(NOP_A, "single_trp");
        step(AREFC, "single_aref");
        trc_body("single_trc");
        ref_end = 1'b1; step(NOP_A, "single_done");
        ref_end = 1'b0; step(NOP_I, "single_idle");

        // Burst of 3: one PRE, AREF every 8 cycles, ref_end on 3rd trca_end only
        ref_set = 1'b1; step(PREC, "burst_pre");
        step(NOP_A, "burst_trp"); step(NOP_A, "burst_trp");
        step(AREFC, "burst_aref1"); trc_body("burst_trc1");
        step(AREFC, "burst_aref2"); trc_body("burst_trc2");
        step(AREFC, "burst_aref3");
        for (int i = 0; i < 5; i++) step(TRC_S, "burst_trc3");
        step(TRC_E, "burst_trc3_e1");
        ref_end = 1'b1; step(TRC_E, "burst_trc3_e2");
        ref_end = 1'b0; step(NOP_A, "burst_done_latched");
        ref_set = 1'b0; step(NOP_I, "burst_idle");

        // Collision: wen with ref_set -> refresh wins, grant after return
        wen = 1'b1; ref_set = 1'b1; step(PREC, "coll_pre_no_grant");
        ref_set = 1'b0; step(NOP_A, "coll_trp"); step(NOP_A, "coll_trp");
        step(AREFC, "coll_aref");
        trc_body("coll_trc");
        step(NOP_I, "coll_back_idle");
        step(GRANT, "coll_grant");
        wen = 1'b0; step(NOP_I, "coll_grant_end");

        // busy_rw when ref_set rises -> WAIT_RW, then PRE
        busy_rw = 1'b1; ref_set = 1'b1; step(NOP_A, "busy_wait");
        step(NOP_A, "busy_wait");
        busy_rw = 1'b0; step(PREC, "busy_pre");
        ref_set = 1'b0; step(NOP_A, "busy_trp"); step(NOP_A, "busy_trp");
        step(AREFC, "busy_aref");
        step(TRC_S, "abort_trc"); step(TRC_S, "abort_trc");

        // Abort: init_done drops during TRC
        init_done = 1'b0; step(NOP_I, "abort_idle");
        step(NOP_I, "abort_quiet");
        ref_set = 1'b1; step(NOP_I, "abort_no_cmd");
        ref_set = 1'b0; init_done = 1'b1; step(NOP_I, "abort_recover");

        // Reset mid-sequence
        ref_set = 1'b1; step(PREC, "midrst_pre");
        ref_set = 1'b0; step(NOP_A, "midrst_trp");
        s_resetn = 1'b0; step(NOP_I, "midrst_reset");
        s_resetn = 1'b1; step(NOP_I, "midrst_idle");
        step(NOP_I, "midrst_no_aref");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
